// File: rtl/gp_timer.sv
// gp_timer: general-purpose timer with a programmable prescaler, one-shot and periodic
// modes, a sticky overflow flag and a register-mapped host interface.
// Optional feature: define GP_TIMER_PWM_EN to implement the CMP register and PWM output.
// Register map: 0 CTRL, 1 PERIOD, 2 PSC, 3 CMP, 4 CNT, 5-7 read as zero.
module gp_timer #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PSC_WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_we,
    input  logic [2:0]       i_addr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_trig,
    output logic             o_irq,
    output logic             o_pwm
);

    localparam logic [2:0] AddrCtrl   = 3'd0;
    localparam logic [2:0] AddrPeriod = 3'd1;
    localparam logic [2:0] AddrPsc    = 3'd2;
    localparam logic [2:0] AddrCmp    = 3'd3;
    localparam logic [2:0] AddrCnt    = 3'd4;

    logic                 en_q, en_d;
    logic                 oneshot_q, oneshot_d;
    logic                 irq_en_q, irq_en_d;
    logic                 flag_q, flag_d;
    logic [WIDTH-1:0]     period_q, period_d;
    logic [PSC_WIDTH-1:0] psc_q, psc_d;
    logic [WIDTH-1:0]     cnt_q, cnt_d;
    logic [PSC_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                 trig_q, trig_d;

    logic tick;
    logic ovf;

    assign tick = en_q && (pcnt_q == psc_q);
    assign ovf  = tick && (cnt_q == period_q);

`ifdef GP_TIMER_PWM_EN
    logic [WIDTH-1:0] cmp_q, cmp_d;
    logic             pwm_q, pwm_d;

    // CMP register and PWM level, both from current-cycle state
    always_comb begin
        cmp_d = cmp_q;
        if (i_we && (i_addr == AddrCmp)) begin
            cmp_d = i_data;
        end
        pwm_d = en_q && (cnt_q < cmp_q);
    end

    // PWM state registers
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            cmp_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cmp_q <= cmp_d;
            pwm_q <= pwm_d;
        end
    end

    assign o_pwm = pwm_q;
`else
    logic [WIDTH-1:0] cmp_q;
    assign cmp_q = '0;
    assign o_pwm = 1'b0;
`endif

    // Next-state: counting first, then host writes override CNT/pcnt/EN; overflow beats FLAG clear
    always_comb begin
        en_d      = en_q;
        oneshot_d = oneshot_q;
        irq_en_d  = irq_en_q;
        flag_d    = flag_q;
        period_d  = period_q;
        psc_d     = psc_q;
        cnt_d     = cnt_q;
        pcnt_d    = pcnt_q;
        trig_d    = 1'b0;

        if (en_q) begin
            pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        end
        if (tick) begin
            cnt_d = ovf ? '0 : cnt_q + 1'b1;
        end

        if (i_we) begin
            case (i_addr)
                AddrCtrl: begin
                    en_d      = i_data[0];
                    oneshot_d = i_data[1];
                    irq_en_d  = i_data[2];
                    if (i_data[3]) begin
                        flag_d = 1'b0;
                    end
                end
                AddrPeriod: begin
                    period_d = i_data;
                    cnt_d    = '0;
                    pcnt_d   = '0;
                end
                AddrPsc: begin
                    psc_d  = i_data[PSC_WIDTH-1:0];
                    cnt_d  = '0;
                    pcnt_d = '0;
                end
                AddrCnt: begin
                    cnt_d  = i_data;
                    pcnt_d = '0;
                end
                default: ;
            endcase
        end

        if (ovf) begin
            flag_d = 1'b1;
            trig_d = 1'b1;
            // A one-shot stop yields to an EN value written on the same edge
            if (oneshot_q && !(i_we && (i_addr == AddrCtrl))) begin
                en_d = 1'b0;
            end
        end
    end

    // State registers
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            en_q      <= 1'b0;
            oneshot_q <= 1'b0;
            irq_en_q  <= 1'b0;
            flag_q    <= 1'b0;
            period_q  <= '0;
            psc_q     <= '0;
            cnt_q     <= '0;
            pcnt_q    <= '0;
            trig_q    <= 1'b0;
        end else begin
            en_q      <= en_d;
            oneshot_q <= oneshot_d;
            irq_en_q  <= irq_en_d;
            flag_q    <= flag_d;
            period_q  <= period_d;
            psc_q     <= psc_d;
            cnt_q     <= cnt_d;
            pcnt_q    <= pcnt_d;
            trig_q    <= trig_d;
        end
    end

    // Combinational read mux
    always_comb begin
        o_data = '0;
        case (i_addr)
            AddrCtrl: begin
                o_data[0] = en_q;
                o_data[1] = oneshot_q;
                o_data[2] = irq_en_q;
                o_data[4] = flag_q;
            end
            AddrPeriod: o_data = period_q;
            AddrPsc:    o_data[PSC_WIDTH-1:0] = psc_q;
            AddrCmp:    o_data = cmp_q;
            AddrCnt:    o_data = cnt_q;
            default:    o_data = '0;
        endcase
    end

    assign o_trig = trig_q;
    assign o_irq  = flag_q & irq_en_q;

endmodule
